// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame FSM states, prefix and
// system-byte codes, and frame geometry.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Keyboard-to-host status bytes that never form a key event
  localparam logic [7:0] PS2_SYS_BAT    = 8'hAA;
  localparam logic [7:0] PS2_SYS_ACK    = 8'hFA;
  localparam logic [7:0] PS2_SYS_RESEND = 8'hFE;
  localparam logic [7:0] PS2_SYS_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_SYS_ERR0   = 8'h00;
  localparam logic [7:0] PS2_SYS_ERR1   = 8'hFF;

  // start + data + parity + stop
  localparam int PS2_FRAME_LEN = 11;
  localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

  function automatic logic ps2_is_sys(input logic [7:0] b);
    return (b == PS2_SYS_BAT)    || (b == PS2_SYS_ACK)  ||
           (b == PS2_SYS_RESEND) || (b == PS2_SYS_ECHO) ||
           (b == PS2_SYS_ERR0)   || (b == PS2_SYS_ERR1);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the asynchronous PS/2 clock and data lines into the clk domain and
// flags the falling edge of the keyboard clock. Flops reset high to match the
// idle level of the open-collector bus, so releasing reset never fakes an edge.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic ps2_dat_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;

  // Synchroniser chains plus one history flop on the clock line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ps2_dat_o = dat_sync_q[SYNC_STAGES-1];
  assign fall_o    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: frames 11-bit packets, exposes every good
// byte on a raw tap, and folds E0/F0 prefixes into single key events.
// Optional watchdog abort of stalled frames: define PS2_TIMEOUT_EN.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  output logic       frame_err
);

  logic       dat_s, fall;
  ps2_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic [7:0] rx_byte_q, rx_byte_d, key_code_q, key_code_d;
  logic       rx_valid_q, rx_valid_d, key_valid_q, key_valid_d;
  logic       key_ext_q, key_ext_d, key_rel_q, key_rel_d;
  logic       frame_err_q, frame_err_d;
  logic       frame_ok, timeout;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk_i (PS2_CLK),
    .ps2_dat_i (PS2_DAT),
    .ps2_dat_o (dat_s),
    .fall_o    (fall)
  );

  // Stop bit high and odd ones-count over data plus parity
  assign frame_ok = dat_s & (^{shift_q, par_q});

`ifdef PS2_TIMEOUT_EN
  localparam int WDT_W = $clog2(TIMEOUT_CYCLES);
  logic [WDT_W-1:0] wdt_q;

  // Watchdog counts idle clk cycles while a frame is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wdt_q <= '0;
    else if (state_q == IDLE || fall || timeout) wdt_q <= '0;
    else                                        wdt_q <= wdt_q + 1'b1;
  end

  assign timeout = (state_q != IDLE) && (wdt_q == WDT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_rel_q   <= key_rel_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame FSM and prefix sequencer; everything advances on a clock fall
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_rel_d   = key_rel_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;

    if (timeout) begin
      // a fall coinciding with the abort is deliberately dropped
      state_d     = IDLE;
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (frame_ok) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
            if (shift_q == PS2_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
              brk_d = 1'b1;
            end else begin
              ext_d = 1'b0;
              brk_d = 1'b0;
              if (!ps2_is_sys(shift_q)) begin
                key_code_d  = shift_q;
                key_ext_d   = ext_q;
                key_rel_d   = brk_q;
                key_valid_d = 1'b1;
              end
            end
          end else begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_valid_q;
  assign key_code      = key_code_q;
  assign key_ext       = key_ext_q;
  assign key_release   = key_rel_q;
  assign key_valid     = key_valid_q;
  assign frame_err     = frame_err_q;

endmodule
